multdiv_unit: RTL and testbench
===============================

Name: multdiv_unit

Overview:
- Multicycle signed multiply/divide unit. It is the iterative counterpart to the single-cycle ALU and sits beside it in the execute stage.
- The pipeline issues an operation with a one-cycle ctrl_MULT or ctrl_DIV pulse and stalls until data_resultRDY pulses.
- The block is the responder on that issue/ready interface. It returns a WIDTH-bit result plus an exception flag.

Parameters:
- WIDTH, 32, operand and result width. Must be even and at least 4.

Ports:
- clock  input  1  single clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- data_operandA  input  WIDTH  multiplicand / dividend; sampled only on a start pulse
- data_operandB  input  WIDTH  multiplier / divisor; sampled only on a start pulse
- ctrl_MULT  input  1  one-cycle start pulse for a signed multiply
- ctrl_DIV  input  1  one-cycle start pulse for a signed divide
- data_result  output  WIDTH  registered result; holds its value between ready pulses
- data_exception  output  1  registered; qualified by data_resultRDY
- data_resultRDY  output  1  one-cycle pulse when data_result and data_exception are valid

Behaviour:
- Reset (async, reset_n=0): state=IDLE, data_result=0, data_exception=0, data_resultRDY=0, counter=0. Reset mid-operation discards the operation; no ready pulse follows.
- States: IDLE, MULT, DIV, DONE.
- Start (any state):
  - ctrl_MULT=1 latches the operands and goes to MULT. ctrl_DIV=1 latches the operands and goes to DIV.
  - Both high in the same cycle: MULT wins, DIV is ignored.
  - A start while in MULT or DIV aborts the in-flight operation and restarts; the aborted operation never produces a ready pulse.
- Latency: the start pulse is cycle 0.
  - MULT: radix-4 Booth, WIDTH/2 iterations. data_resultRDY=1 in cycle WIDTH/2+1 (17 for WIDTH=32).
  - DIV: non-restoring, on magnitudes, WIDTH iterations. data_resultRDY=1 in cycle WIDTH+1 (33).
- DONE lasts exactly one cycle: data_resultRDY=1, then back to IDLE. A start coincident with DONE is accepted normally.
- Multiply arithmetic:
  - The full 2*WIDTH-bit signed product is formed. data_result is the low WIDTH bits.
  - data_exception=1 iff the upper WIDTH+1 bits of the product are not all equal (overflow).
- Divide arithmetic:
  - Signed quotient, truncated toward zero. The remainder is not output.
  - Divisor 0: result 0, data_exception=1.
  - Dividend = most negative value and divisor = -1: result = most negative value, data_exception=1.
  - Otherwise data_exception=0.
- Outputs change only on ready cycles; data_result and data_exception hold their values otherwise.
- data_operandA and data_operandB may change freely after cycle 0 without affecting the operation.

Optional Feature:
- MULTDIV_EARLY_EXIT_EN defined: on a start, the block finishes in 1 cycle (data_resultRDY in cycle 1) if any of these hold:
  - MULT with either operand 0 -> result 0, exception 0.
  - DIV with divisor 0 -> result 0, exception 1.
  - DIV with dividend 0 -> result 0, exception 0.
- Not defined: every operation takes the full latency, including divide-by-zero. Results and exceptions are identical in both builds; only timing differs.

Decomposition:
- Package multdiv_pkg holds:
  - state enum (IDLE, MULT, DIV, DONE);
  - op enum (OP_MULT, OP_DIV);
  - localparams MULT_CYCLES=WIDTH/2 and DIV_CYCLES=WIDTH;
  - Booth digit encoding type (-2..+2).
- One combinational sub-module, booth_recode: takes a 3-bit multiplier window and returns a digit select (zero, ±1x, ±2x).
- The datapath and FSM stay in multdiv_unit.

Test Plan:
- MULT 7 x -3 -> data_resultRDY only in cycle 17; result 0xFFFFFFEB, exception 0.
- MULT 0x00010000 x 0x00010000 -> cycle 17: result 0x00000000, exception 1. MULT 0x7FFFFFFF x 1 -> 0x7FFFFFFF, exception 0.
- DIV -100 / 7 -> only in cycle 33: result 0xFFFFFFF2 (-14), exception 0. DIV 0x80000000 / -1 -> result 0x80000000, exception 1.
- DIV 5 / 0 -> result 0, exception 1, in cycle 33 (cycle 1 with MULTDIV_EARLY_EXIT_EN).
- Restart:
  - MULT 3x3, then ctrl_DIV 20/4 in cycle 5 -> no ready pulse for the MULT; ready in cycle 38 with result 5.
  - ctrl_MULT and ctrl_DIV together -> multiply result in cycle 17.
- Reset mid-operation: start DIV, pull reset_n low in cycle 8 (asynchronously, between edges) -> outputs 0 immediately; no ready pulse for 40 cycles after release. A fresh MULT 2x2 then gives 4 in cycle 17.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types for the iterative multiply/divide unit:
// FSM states, operation kind, Booth digit encoding and default latencies.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        DONE
    } state_e;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } op_e;

    localparam int XLEN        = 32;
    localparam int MULT_CYCLES = XLEN / 2;
    localparam int DIV_CYCLES  = XLEN;

    // Radix-4 Booth digit, one of -2..+2
    typedef enum logic [2:0] {
        BD_ZERO,
        BD_POS1,
        BD_POS2,
        BD_NEG1,
        BD_NEG2
    } booth_digit_e;

endpackage

// File: rtl/multdiv_if.sv
// Issue/ready bundle between the execute stage and the multdiv unit.
// The pipeline is the master; the multdiv unit is the slave.
interface multdiv_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA,
        output data_operandB,
        output ctrl_MULT,
        output ctrl_DIV,
        input  data_result,
        input  data_exception,
        input  data_resultRDY
    );

    modport slave (
        input  data_operandA,
        input  data_operandB,
        input  ctrl_MULT,
        input  ctrl_DIV,
        output data_result,
        output data_exception,
        output data_resultRDY
    );
endinterface

// File: rtl/multdiv_unit_booth_recode.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window
// {b[2i+1], b[2i], b[2i-1]} to a digit select.
module booth_recode
    import multdiv_pkg::*;
(
    input  logic [2:0]   win,
    output booth_digit_e digit
);

    // Pure lookup of the standard Booth table
    always_comb begin
        digit = BD_ZERO;
        unique case (win)
            3'b000, 3'b111: digit = BD_ZERO;
            3'b001, 3'b010: digit = BD_POS1;
            3'b011:         digit = BD_POS2;
            3'b100:         digit = BD_NEG2;
            3'b101, 3'b110: digit = BD_NEG1;
            default:        digit = BD_ZERO;
        endcase
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-4 Booth) / divide (non-restoring).
// Optional build macro MULTDIV_EARLY_EXIT_EN: one-cycle finish on zero operands.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clock,
    input  logic     reset_n,
    multdiv_if.slave bus
);

    localparam int W2     = 2 * WIDTH;
    localparam int MULT_N = WIDTH / 2;
    localparam int DIV_N  = WIDTH;
    localparam int CW     = $clog2(WIDTH) + 1;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W2-1:0]    prod_q, prod_d;
    logic [W2-1:0]    mcand_q, mcand_d;
    logic [WIDTH:0]   mplr_q, mplr_d;
    logic [WIDTH+1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             neg_q, neg_d;
    logic             div0_q, div0_d;
    logic             dovf_q, dovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;

    booth_digit_e     digit;
    logic [W2-1:0]    pp;
    logic [W2-1:0]    prod_nxt;
    logic [WIDTH:0]   prod_hi;
    logic             mult_ovf;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] quo_signed;
    logic             start;
    op_e              start_op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             b_zero;
    logic             a_zero;
    logic             min_by_m1;

    booth_recode u_recode (
        .win   (mplr_q[2:0]),
        .digit (digit)
    );

    assign opa       = bus.data_operandA;
    assign opb       = bus.data_operandB;
    assign a_zero    = (opa == '0);
    assign b_zero    = (opb == '0);
    assign min_by_m1 = (opa == {1'b1, {(WIDTH-1){1'b0}}}) && (opb == '1);
    assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
    assign start_op  = bus.ctrl_MULT ? OP_MULT : OP_DIV;

    // One Booth step and one non-restoring step, evaluated every cycle
    always_comb begin
        pp = '0;
        unique case (digit)
            BD_POS1: pp = mcand_q;
            BD_POS2: pp = mcand_q << 1;
            BD_NEG1: pp = -mcand_q;
            BD_NEG2: pp = -(mcand_q << 1);
            default: pp = '0;
        endcase
        prod_nxt   = prod_q + pp;
        prod_hi    = prod_nxt[W2-1:WIDTH-1];
        mult_ovf   = !((&prod_hi) || (~|prod_hi));
        rem_sh     = {rem_q[WIDTH:0], quo_q[WIDTH-1]};
        rem_nxt    = rem_q[WIDTH+1] ? rem_sh + {2'b00, dvsr_q}
                                    : rem_sh - {2'b00, dvsr_q};
        quo_nxt    = {quo_q[WIDTH-2:0], ~rem_nxt[WIDTH+1]};
        quo_signed = neg_q ? -quo_nxt : quo_nxt;
    end

    // Next-state, datapath update and start/abort handling
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        dovf_d   = dovf_q;
        result_d = result_q;
        exc_d    = exc_q;

        unique case (state_q)
            MULT: begin
                prod_d  = prod_nxt;
                mcand_d = mcand_q << 2;
                mplr_d  = {{2{mplr_q[WIDTH]}}, mplr_q[WIDTH:2]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(MULT_N - 1)) begin
                    state_d  = DONE;
                    result_d = prod_nxt[WIDTH-1:0];
                    exc_d    = mult_ovf;
                end
            end
            DIV: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DIV_N - 1)) begin
                    state_d  = DONE;
                    result_d = div0_q ? '0 : quo_signed;
                    exc_d    = div0_q | dovf_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (start) begin
            cnt_d = '0;
            if (start_op == OP_MULT) begin
                state_d = MULT;
                prod_d  = '0;
                mcand_d = {{WIDTH{opa[WIDTH-1]}}, opa};
                mplr_d  = {opb, 1'b0};
`ifdef MULTDIV_EARLY_EXIT_EN
                if (a_zero || b_zero) begin
                    state_d  = DONE;
                    result_d = '0;
                    exc_d    = 1'b0;
                end
`endif
            end else begin
                state_d = DIV;
                rem_d   = '0;
                quo_d   = mag(opa);
                dvsr_d  = mag(opb);
                neg_d   = opa[WIDTH-1] ^ opb[WIDTH-1];
                div0_d  = b_zero;
                dovf_d  = min_by_m1;
`ifdef MULTDIV_EARLY_EXIT_EN
                if (b_zero || a_zero) begin
                    state_d  = DONE;
                    result_d = '0;
                    exc_d    = b_zero;
                end
`endif
            end
        end
    end

    // State and datapath registers; reset discards any operation
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            dovf_q   <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            dovf_q   <= dovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state_q == DONE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: vector table plus
// restart, dual-start and mid-operation reset sequences.
module tb_multdiv_unit;

`ifdef MULTDIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    localparam int NV = 22;

    logic clock;
    logic reset_n;
    int   n_chk;
    int   n_pass;
    vec_t vecs[NV];

    multdiv_if #(.WIDTH(32)) bus ();

    multdiv_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic int exp_lat(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        if (EARLY && (a == 0 || b == 0)) return 1;
        return c[1] ? 17 : 33;
    endfunction

    // Issue one op; return first ready cycle (-1 if none) and outputs
    task automatic run_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic [31:0] res, output logic exc);
        @(negedge clock);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = c[1];
        bus.ctrl_DIV      = c[0];
        cyc = -1;
        res = '0;
        exc = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (k == 1) begin
                bus.ctrl_MULT     = 1'b0;
                bus.ctrl_DIV      = 1'b0;
                bus.data_operandA = $urandom;
                bus.data_operandB = $urandom;
            end
            if (bus.data_resultRDY) begin
                cyc = k;
                res = bus.data_result;
                exc = bus.data_exception;
                break;
            end
        end
    endtask

    int          cyc;
    int          first;
    int          rdy_cnt;
    logic [31:0] res;
    logic        exc;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        vecs[0]  = '{2'b10, 32'd7,        -32'sd3,      32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{2'b10, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
        vecs[2]  = '{2'b10, 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0};
        vecs[3]  = '{2'b10, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
        vecs[4]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        vecs[5]  = '{2'b10, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
        vecs[6]  = '{2'b10, 32'd0,        32'd12345,    32'h00000000, 1'b0};
        vecs[7]  = '{2'b10, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 1'b1};
        vecs[8]  = '{2'b10, 32'd12345,    -32'sd6789,   32'hFB012863, 1'b0};
        vecs[9]  = '{2'b11, 32'd6,        32'd7,        32'd42,       1'b0};
        vecs[10] = '{2'b01, -32'sd100,    32'd7,        32'hFFFFFFF2, 1'b0};
        vecs[11] = '{2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[12] = '{2'b01, 32'd5,        32'd0,        32'h00000000, 1'b1};
        vecs[13] = '{2'b01, 32'd100,      -32'sd7,      32'hFFFFFFF2, 1'b0};
        vecs[14] = '{2'b01, -32'sd100,    -32'sd7,      32'd14,       1'b0};
        vecs[15] = '{2'b01, 32'd7,        32'd100,      32'd0,        1'b0};
        vecs[16] = '{2'b01, 32'd0,        32'd5,        32'd0,        1'b0};
        vecs[17] = '{2'b01, 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0};
        vecs[18] = '{2'b01, 32'h80000000, 32'd2,        32'hC0000000, 1'b0};
        vecs[19] = '{2'b01, 32'h80000000, 32'h80000000, 32'd1,        1'b0};
        vecs[20] = '{2'b01, 32'd20,       32'd4,        32'd5,        1'b0};
        vecs[21] = '{2'b01, 32'd0,        32'd0,        32'd0,        1'b1};

        reset_n           = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(negedge clock);
        chk("reset_result", bus.data_result, 32'd0);
        chk("reset_exc", {31'd0, bus.data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, cyc, res, exc);
            chk($sformatf("vec%0d_latency", i), 32'(cyc),
                32'(exp_lat(vecs[i].ctrl, vecs[i].a, vecs[i].b)));
            chk($sformatf("vec%0d_result", i), res, vecs[i].res);
            chk($sformatf("vec%0d_exc", i), {31'd0, exc}, {31'd0, vecs[i].exc});
            @(negedge clock);
            chk($sformatf("vec%0d_rdy_pulse", i), {31'd0, bus.data_resultRDY}, 32'd0);
            chk($sformatf("vec%0d_hold", i), bus.data_result, vecs[i].res);
        end

        // Restart: MULT 3x3 aborted by DIV 20/4 issued in cycle 5
        @(negedge clock);
        bus.data_operandA = 32'd3;
        bus.data_operandB = 32'd3;
        bus.ctrl_MULT     = 1'b1;
        first = -1;
        res   = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (k == 1) bus.ctrl_MULT = 1'b0;
            if (k == 5) begin
                bus.data_operandA = 32'd20;
                bus.data_operandB = 32'd4;
                bus.ctrl_DIV      = 1'b1;
            end
            if (k == 6) begin
                bus.ctrl_DIV      = 1'b0;
                bus.data_operandA = $urandom;
                bus.data_operandB = $urandom;
            end
            if (bus.data_resultRDY) begin
                first = k;
                res   = bus.data_result;
                break;
            end
        end
        chk("restart_latency", 32'(first), 32'd38);
        chk("restart_result", res, 32'd5);
        @(negedge clock);

        // Reset mid-operation
        run_op(2'b10, 32'd2, 32'd3, cyc, res, exc);
        chk("pre_reset_result", res, 32'd6);
        @(negedge clock);
        bus.data_operandA = 32'd100;
        bus.data_operandB = 32'd7;
        bus.ctrl_DIV      = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) bus.ctrl_DIV = 1'b0;
        end
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_result", bus.data_result, 32'd0);
        chk("async_reset_exc", {31'd0, bus.data_exception}, 32'd0);
        chk("async_reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        rdy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (bus.data_resultRDY) rdy_cnt++;
        end
        chk("no_rdy_after_reset", 32'(rdy_cnt), 32'd0);
        run_op(2'b10, 32'd2, 32'd2, cyc, res, exc);
        chk("post_reset_latency", 32'(cyc), 32'd17);
        chk("post_reset_result", res, 32'd4);
        chk("post_reset_exc", {31'd0, exc}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
